// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port arbiter in front of a shared single-cycle data memory
//
// Purpose:
//   Ports a and b issue load/store commands to one shared data memory. Each
//   clock edge the arbiter picks at most one pending command and latches it
//   into a single command slot. The slot drives the memory for exactly one
//   ACCESS cycle. The owner gets a one-cycle rvalid in the following cycle,
//   with read data (0 for writes and rejected commands) and an error flag.
//   Commands with an illegal type or a misaligned address are flagged when
//   they are latched and never write memory.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   x_req, x_we       request / write enable, x in {a, b}
//   x_type [2:0]      000 word, 010/011 half, 100/101 byte,
//                     110 word-left, 111 word-right, 001 illegal
//   x_addr/wd/pc      byte address, write data, issuing pc (32 bits each)
//   x_gnt             high for the single ACCESS cycle serving port x
//   x_rvalid, x_err   one-cycle response pulse and its error flag
//   x_rdata [31:0]    response data, held until port x's next rvalid
//   dm_we/type/addr/wd/pc   memory command, all zero while IDLE
//   dm_rd [31:0]      combinational memory read data for dm_addr
//
// Parameter:
//   WIDTH             address width of the memory behind dm_*; addresses
//                     are forwarded at full 32 bits and the memory decodes
//                     what it needs
//
// Build option:
//   DM_ARB_ROUND_ROBIN_EN  defined: a tie goes to the port not granted most
//                          recently. Undefined: a tie always goes to port a.

module dm_arbiter #(
   parameter int WIDTH = 12
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        a_req,
   input  logic        a_we,
   input  logic [2:0]  a_type,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wd,
   input  logic [31:0] a_pc,
   output logic        a_gnt,
   output logic        a_rvalid,
   output logic        a_err,
   output logic [31:0] a_rdata,

   input  logic        b_req,
   input  logic        b_we,
   input  logic [2:0]  b_type,
   input  logic [31:0] b_addr,
   input  logic [31:0] b_wd,
   input  logic [31:0] b_pc,
   output logic        b_gnt,
   output logic        b_rvalid,
   output logic        b_err,
   output logic [31:0] b_rdata,

   output logic        dm_we,
   output logic [2:0]  dm_type,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wd,
   output logic [31:0] dm_pc,
   input  logic [31:0] dm_rd
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   // The command slot. type/addr/wd/pc live directly in the dm_* output
   // registers; they are zeroed whenever no command is latched, so the
   // memory bus reads all zero in IDLE without extra gating.
   state_t      state;
   logic        owner_b;      // 0 = slot belongs to port a, 1 = port b
   logic        slot_we;      // requested write, kept separately from dm_we
   logic        slot_err;     // command rejected at latch time

   logic        a_elig;
   logic        b_elig;
   logic        win_valid;
   logic        win_b;
   logic        tie_pick_b;
   logic        win_we;
   logic [2:0]  win_type;
   logic [31:0] win_addr;
   logic [31:0] win_wd;
   logic [31:0] win_pc;
   logic        win_err;
   logic [31:0] resp_data;

   if (WIDTH < 1 || WIDTH > 32) begin : g_width_beyond_bus
      // A WIDTH outside 1..32 is the memory's concern; the bus stays 32 bits.
   end

   // Illegal type, or an address not aligned to the access size. The
   // word-left/right and byte forms accept any address.
   function automatic logic cmd_illegal(input logic [2:0] cmd_type,
                                        input logic [1:0] addr_lo);
      logic bad;
      case (cmd_type)
         3'b001:         bad = 1'b1;
         3'b000:         bad = (addr_lo != 2'b00);
         3'b010, 3'b011: bad = addr_lo[0];
         default:        bad = 1'b0;
      endcase
      return bad;
   endfunction

   always_comb begin
      // The port holding the slot this cycle is still presenting the command
      // being served; its req is not a new request until gnt has been seen.
      a_elig    = a_req & ~a_gnt;
      b_elig    = b_req & ~b_gnt;
      win_valid = a_elig | b_elig;
      win_b     = (a_elig & b_elig) ? tie_pick_b : b_elig;

      win_we    = win_b ? b_we   : a_we;
      win_type  = win_b ? b_type : a_type;
      win_addr  = win_b ? b_addr : a_addr;
      win_wd    = win_b ? b_wd   : a_wd;
      win_pc    = win_b ? b_pc   : a_pc;
      win_err   = cmd_illegal(win_type, win_addr[1:0]);

      // Read data is sampled from the memory during ACCESS; writes and
      // rejected commands answer with zero.
      resp_data = (slot_we | slot_err) ? 32'h0 : dm_rd;
   end

`ifdef DM_ARB_ROUND_ROBIN_EN
   // Last granted port; starts at b so that a wins the first tie.
   logic last_b;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_b <= 1'b1;
      end else if (win_valid) begin
         last_b <= win_b;
      end
   end

   assign tie_pick_b = ~last_b;
`else
   assign tie_pick_b = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         // A command caught in ACCESS is dropped here: no rvalid follows it.
         state    <= IDLE;
         owner_b  <= 1'b0;
         slot_we  <= 1'b0;
         slot_err <= 1'b0;
         a_gnt    <= 1'b0;
         b_gnt    <= 1'b0;
         dm_we    <= 1'b0;
         dm_type  <= 3'b000;
         dm_addr  <= 32'h0;
         dm_wd    <= 32'h0;
         dm_pc    <= 32'h0;
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         a_err    <= 1'b0;
         b_err    <= 1'b0;
         a_rdata  <= 32'h0;
         b_rdata  <= 32'h0;
      end else begin
         // Response for the command leaving the slot at this edge.
         a_rvalid <= (state == ACCESS) && !owner_b;
         b_rvalid <= (state == ACCESS) &&  owner_b;
         a_err    <= (state == ACCESS) && !owner_b && slot_err;
         b_err    <= (state == ACCESS) &&  owner_b && slot_err;
         if (state == ACCESS) begin
            if (owner_b) begin
               b_rdata <= resp_data;
            end else begin
               a_rdata <= resp_data;
            end
         end

         // Next occupant of the slot.
         if (win_valid) begin
            state    <= ACCESS;
            owner_b  <= win_b;
            slot_we  <= win_we;
            slot_err <= win_err;
            a_gnt    <= ~win_b;
            b_gnt    <= win_b;
            dm_we    <= win_we & ~win_err;
            dm_type  <= win_type;
            dm_addr  <= win_addr;
            dm_wd    <= win_wd;
            dm_pc    <= win_pc;
         end else begin
            state    <= IDLE;
            owner_b  <= 1'b0;
            slot_we  <= 1'b0;
            slot_err <= 1'b0;
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            dm_we    <= 1'b0;
            dm_type  <= 3'b000;
            dm_addr  <= 32'h0;
            dm_wd    <= 32'h0;
            dm_pc    <= 32'h0;
         end
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter
`timescale 1ns/1ps
module tb_dm_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_req, a_we, b_req, b_we;
   logic [2:0]  a_type, b_type;
   logic [31:0] a_addr, a_wd, a_pc, b_addr, b_wd, b_pc;
   logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
   logic [31:0] a_rdata, b_rdata;
   logic        dm_we;
   logic [2:0]  dm_type;
   logic [31:0] dm_addr, dm_wd, dm_pc, dm_rd;

   int n_checks = 0;
   int n_fail   = 0;

   dm_arbiter #(.WIDTH(12)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_type(a_type), .a_addr(a_addr), .a_wd(a_wd), .a_pc(a_pc),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_err(a_err), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_type(b_type), .b_addr(b_addr), .b_wd(b_wd), .b_pc(b_pc),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_err(b_err), .b_rdata(b_rdata),
      .dm_we(dm_we), .dm_type(dm_type), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_pc(dm_pc),
      .dm_rd(dm_rd)
   );

   always #5 clk = ~clk;

   // Behavioural memory: one 32-bit cell per byte address 0..255.
   logic [31:0] mem [0:255];
   logic        mem_clear;
   assign dm_rd = mem[dm_addr[7:0]];
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      end else if (dm_we) begin
         mem[dm_addr[7:0]] <= dm_wd;
      end
   end

   logic [169:0] all_out;
   assign all_out = {a_gnt, a_rvalid, a_err, a_rdata, b_gnt, b_rvalid, b_err, b_rdata,
                     dm_we, dm_type, dm_addr, dm_wd, dm_pc};

   task automatic set_a(input logic req, input logic we, input logic [2:0] t,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc);
      a_req = req; a_we = we; a_type = t; a_addr = addr; a_wd = wd; a_pc = pc;
   endtask

   task automatic set_b(input logic req, input logic we, input logic [2:0] t,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc);
      b_req = req; b_we = we; b_type = t; b_addr = addr; b_wd = wd; b_pc = pc;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      set_a(0, 0, 0, 0, 0, 0);
      set_b(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      mem_clear = 1'b0;
      a_req = 1'b1;
      b_req = 1'b1;
      @(negedge clk);
      n_checks++;
      if (all_out !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, want all zero", all_out);
      end
      reset = 1'b0;
      a_req = 1'b0;
      b_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if (all_out !== '0) begin
         n_fail++;
         $display("FAIL reset_idle: got %h, want all zero", all_out);
      end
   endtask

   task automatic test_word_write_read();
      do_reset();
      set_a(1, 1, 3'b000, 32'h10, 32'hDEAD_BEEF, 32'h100);
      @(negedge clk);
      n_checks++;
      if ({a_gnt, b_gnt, dm_we} !== 3'b101 || dm_addr !== 32'h10 || dm_wd !== 32'hDEAD_BEEF
          || dm_type !== 3'b000 || dm_pc !== 32'h100) begin
         n_fail++;
         $display("FAIL wr_access: gnt=%b%b we=%b addr=%h wd=%h type=%b pc=%h, want 1 0 1 10 deadbeef 000 100",
                  a_gnt, b_gnt, dm_we, dm_addr, dm_wd, dm_type, dm_pc);
      end
      set_a(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_checks++;
      if ({a_rvalid, a_err, a_gnt, dm_we} !== 4'b1000 || a_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL wr_ack: rvalid=%b err=%b gnt=%b dm_we=%b rdata=%h, want 1 0 0 0 0",
                  a_rvalid, a_err, a_gnt, dm_we, a_rdata);
      end
      set_a(1, 0, 3'b000, 32'h10, 32'h0, 32'h104);
      @(negedge clk);
      n_checks++;
      if ({a_gnt, dm_we} !== 2'b10 || dm_addr !== 32'h10) begin
         n_fail++;
         $display("FAIL rd_access: gnt=%b dm_we=%b addr=%h, want 1 0 10", a_gnt, dm_we, dm_addr);
      end
      set_a(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_checks++;
      if (a_rvalid !== 1'b1 || a_err !== 1'b0 || a_rdata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL rd_data: rvalid=%b err=%b rdata=%h, want 1 0 deadbeef", a_rvalid, a_err, a_rdata);
      end
      @(negedge clk);
      n_checks++;
      if (a_rvalid !== 1'b0 || a_rdata !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL rd_hold: rvalid=%b rdata=%h, want 0 deadbeef", a_rvalid, a_rdata);
      end
   endtask

   task automatic test_tie();
      logic exp_b;
      do_reset();
      set_a(1, 0, 3'b000, 32'h40, 0, 32'h1);
      set_b(1, 0, 3'b000, 32'h44, 0, 32'h2);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exp_b = (i % 2) == 1;
         n_checks++;
         if ({a_gnt, b_gnt} !== {~exp_b, exp_b}) begin
            n_fail++;
            $display("FAIL tie_seq[%0d]: got a=%b b=%b, want a=%b b=%b", i, a_gnt, b_gnt, ~exp_b, exp_b);
         end
      end
      set_a(0, 0, 0, 0, 0, 0);
      set_b(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      set_a(1, 0, 3'b000, 32'h48, 0, 32'h3);
      @(negedge clk);
      n_checks++;
      if ({a_gnt, b_gnt} !== 2'b10) begin
         n_fail++;
         $display("FAIL lone_a: got a=%b b=%b, want a=1 b=0", a_gnt, b_gnt);
      end
      set_a(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      set_a(1, 0, 3'b000, 32'h4C, 0, 32'h4);
      set_b(1, 0, 3'b000, 32'h50, 0, 32'h5);
`ifdef DM_ARB_ROUND_ROBIN_EN
      exp_b = 1'b1;
`else
      exp_b = 1'b0;
`endif
      @(negedge clk);
      n_checks++;
      if ({a_gnt, b_gnt} !== {~exp_b, exp_b}) begin
         n_fail++;
         $display("FAIL tie_after_a: got a=%b b=%b, want a=%b b=%b", a_gnt, b_gnt, ~exp_b, exp_b);
      end
      if (exp_b) set_b(0, 0, 0, 0, 0, 0);
      else set_a(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_checks++;
      if ({a_gnt, b_gnt} !== {exp_b, ~exp_b}) begin
         n_fail++;
         $display("FAIL tie_loser: got a=%b b=%b, want a=%b b=%b", a_gnt, b_gnt, exp_b, ~exp_b);
      end
      set_a(0, 0, 0, 0, 0, 0);
      set_b(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_errors();
      logic [2:0]  tt [0:5];
      logic [31:0] ta [0:5];
      logic        tw [0:5];
      logic        te [0:5];
      tt = '{3'b001, 3'b000, 3'b011, 3'b100, 3'b010, 3'b110};
      ta = '{32'h20, 32'h12, 32'h12, 32'h13, 32'h11, 32'h03};
      tw = '{1'b0,   1'b1,   1'b1,   1'b1,   1'b0,   1'b1};
      te = '{1'b1,   1'b1,   1'b0,   1'b0,   1'b1,   1'b0};
      set_b(1, 1, 3'b010, 32'h13, 32'h1234, 32'h200);
      @(negedge clk);
      n_checks++;
      if ({b_gnt, dm_we} !== 2'b10 || dm_type !== 3'b010 || dm_addr !== 32'h13) begin
         n_fail++;
         $display("FAIL half_mis_access: gnt=%b dm_we=%b type=%b addr=%h, want 1 0 010 13",
                  b_gnt, dm_we, dm_type, dm_addr);
      end
      set_b(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_checks++;
      if ({b_rvalid, b_err, dm_we} !== 3'b110 || b_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL half_mis_resp: rvalid=%b err=%b dm_we=%b rdata=%h, want 1 1 0 0",
                  b_rvalid, b_err, dm_we, b_rdata);
      end
      for (int i = 0; i < 6; i++) begin
         set_a(1, tw[i], tt[i], ta[i], 32'h7700_0000 | 32'(i), 32'h300);
         @(negedge clk);
         n_checks++;
         if (a_gnt !== 1'b1 || dm_we !== (tw[i] & ~te[i])) begin
            n_fail++;
            $display("FAIL err_tbl_access[%0d]: gnt=%b dm_we=%b, want 1 %b", i, a_gnt, dm_we, tw[i] & ~te[i]);
         end
         set_a(0, 0, 0, 0, 0, 0);
         @(negedge clk);
         n_checks++;
         if (a_rvalid !== 1'b1 || a_err !== te[i]) begin
            n_fail++;
            $display("FAIL err_tbl_resp[%0d]: rvalid=%b err=%b, want 1 %b", i, a_rvalid, a_err, te[i]);
         end
      end
   endtask

   task automatic test_reset_in_access();
      set_a(1, 1, 3'b000, 32'h30, 32'hCAFE_F00D, 32'h400);
      @(negedge clk);
      n_checks++;
      if ({a_gnt, dm_we} !== 2'b11) begin
         n_fail++;
         $display("FAIL rst_acc_setup: gnt=%b dm_we=%b, want 1 1", a_gnt, dm_we);
      end
      reset = 1'b1;
      set_a(0, 0, 0, 0, 0, 0);
      set_b(1, 0, 3'b000, 32'h34, 0, 32'h404);
      @(negedge clk);
      n_checks++;
      if (all_out !== '0) begin
         n_fail++;
         $display("FAIL rst_acc_abort: got %h, want all zero", all_out);
      end
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({b_gnt, a_rvalid, a_gnt} !== 3'b100) begin
         n_fail++;
         $display("FAIL rst_acc_after: b_gnt=%b a_rvalid=%b a_gnt=%b, want 1 0 0", b_gnt, a_rvalid, a_gnt);
      end
      set_b(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_checks++;
      if ({b_rvalid, a_rvalid} !== 2'b10) begin
         n_fail++;
         $display("FAIL rst_acc_resp: b_rvalid=%b a_rvalid=%b, want 1 0", b_rvalid, a_rvalid);
      end
   endtask

   task automatic test_passthrough();
      set_b(1, 1, 3'b100, 32'h21, 32'h0000_005A, 32'h500);
      @(negedge clk);
      n_checks++;
      if ({b_gnt, dm_we} !== 2'b11 || dm_type !== 3'b100 || dm_addr !== 32'h21 || dm_wd !== 32'h5A) begin
         n_fail++;
         $display("FAIL pt_byte: gnt=%b we=%b type=%b addr=%h wd=%h, want 1 1 100 21 5a",
                  b_gnt, dm_we, dm_type, dm_addr, dm_wd);
      end
      set_b(0, 0, 0, 0, 0, 0);
      set_a(1, 0, 3'b111, 32'h22, 32'h0, 32'h504);
      @(negedge clk);
      n_checks++;
      if ({a_gnt, dm_we, b_rvalid, a_rvalid} !== 4'b1010 || dm_type !== 3'b111 || dm_addr !== 32'h22) begin
         n_fail++;
         $display("FAIL pt_wright: gnt=%b we=%b b_rv=%b a_rv=%b type=%b addr=%h, want 1 0 1 0 111 22",
                  a_gnt, dm_we, b_rvalid, a_rvalid, dm_type, dm_addr);
      end
      set_a(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      n_checks++;
      if ({a_rvalid, b_rvalid} !== 2'b10 || a_rdata !== 32'hA500_0022) begin
         n_fail++;
         $display("FAIL pt_order: a_rv=%b b_rv=%b a_rdata=%h, want 1 0 a5000022", a_rvalid, b_rvalid, a_rdata);
      end
   endtask

   task automatic test_random();
      logic        pend [2];
      logic        f_we [2];
      logic [2:0]  f_type [2];
      logic [31:0] f_addr [2];
      logic [31:0] f_wd [2];
      logic [31:0] f_pc [2];
      logic        e_has, e_own, e_last;
      logic        s_we, s_err;
      logic [2:0]  s_type;
      logic [31:0] s_addr, s_wd, s_pc;
      logic        e_rv [2];
      logic        e_er [2];
      logic [31:0] e_rd [2];
      logic [31:0] exp_mem [0:255];
      logic        el0, el1, w_has, w_own;
      logic [98:0] exp_bus;

      do_reset();
      for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
      e_has = 0; e_own = 0; e_last = 1;
      s_we = 0; s_err = 0; s_type = 0; s_addr = 0; s_wd = 0; s_pc = 0;
      for (int p = 0; p < 2; p++) begin
         pend[p] = 0; e_rv[p] = 0; e_er[p] = 0; e_rd[p] = 0;
         f_we[p] = 0; f_type[p] = 0; f_addr[p] = 0; f_wd[p] = 0; f_pc[p] = 0;
      end

      for (int cyc = 0; cyc < 600; cyc++) begin
         n_checks++;
         if ({a_gnt, b_gnt} !== {e_has & ~e_own, e_has & e_own}) begin
            n_fail++;
            $display("FAIL rnd_gnt cyc=%0d: got %b%b, want %b%b", cyc, a_gnt, b_gnt, e_has & ~e_own, e_has & e_own);
         end
         n_checks++;
         if ({a_rvalid, b_rvalid, a_err, b_err} !== {e_rv[0], e_rv[1], e_er[0], e_er[1]}) begin
            n_fail++;
            $display("FAIL rnd_resp cyc=%0d: got rv=%b%b err=%b%b, want rv=%b%b err=%b%b", cyc,
                     a_rvalid, b_rvalid, a_err, b_err, e_rv[0], e_rv[1], e_er[0], e_er[1]);
         end
         n_checks++;
         if (a_rdata !== e_rd[0]) begin
            n_fail++;
            $display("FAIL rnd_a_rdata cyc=%0d: got %h, want %h", cyc, a_rdata, e_rd[0]);
         end
         n_checks++;
         if (b_rdata !== e_rd[1]) begin
            n_fail++;
            $display("FAIL rnd_b_rdata cyc=%0d: got %h, want %h", cyc, b_rdata, e_rd[1]);
         end
         n_checks++;
         if (dm_we !== (e_has & s_we & ~s_err)) begin
            n_fail++;
            $display("FAIL rnd_dm_we cyc=%0d: got %b, want %b", cyc, dm_we, e_has & s_we & ~s_err);
         end
         exp_bus = e_has ? {s_type, s_addr, s_wd, s_pc} : '0;
         n_checks++;
         if ({dm_type, dm_addr, dm_wd, dm_pc} !== exp_bus) begin
            n_fail++;
            $display("FAIL rnd_dm_bus cyc=%0d: got %h, want %h", cyc, {dm_type, dm_addr, dm_wd, dm_pc}, exp_bus);
         end
         n_checks++;
         if ((a_gnt && b_gnt) || (a_rvalid && b_rvalid)) begin
            n_fail++;
            $display("FAIL rnd_exclusive cyc=%0d: gnt=%b%b rvalid=%b%b, want at most one of each",
                     cyc, a_gnt, b_gnt, a_rvalid, b_rvalid);
         end

         // Requesters: drop on grant, then maybe issue a fresh command.
         for (int p = 0; p < 2; p++) begin
            if (e_has && (e_own == p[0])) pend[p] = 0;
            if (!pend[p] && $urandom_range(0, 99) < 55) begin
               pend[p]   = 1;
               f_we[p]   = 1'($urandom_range(0, 1));
               f_type[p] = 3'($urandom_range(0, 7));
               f_addr[p] = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 255));
               if ($urandom_range(0, 1) == 1) f_addr[p][1:0] = 2'b00;
               f_wd[p]   = $urandom;
               f_pc[p]   = $urandom;
            end
         end
         set_a(pend[0], f_we[0], f_type[0], f_addr[0], f_wd[0], f_pc[0]);
         set_b(pend[1], f_we[1], f_type[1], f_addr[1], f_wd[1], f_pc[1]);

         // What the next edge must produce.
         e_rv[0] = 0; e_rv[1] = 0; e_er[0] = 0; e_er[1] = 0;
         if (e_has) begin
            e_rv[e_own] = 1;
            e_er[e_own] = s_err;
            e_rd[e_own] = (s_we || s_err) ? 32'h0 : exp_mem[s_addr[7:0]];
            if (s_we && !s_err) exp_mem[s_addr[7:0]] = s_wd;
         end
         el0 = pend[0] && !(e_has && !e_own);
         el1 = pend[1] && !(e_has && e_own);
         w_has = el0 || el1;
`ifdef DM_ARB_ROUND_ROBIN_EN
         w_own = (el0 && el1) ? ~e_last : el1;
`else
         w_own = (el0 && el1) ? 1'b0 : el1;
`endif
         if (w_has) begin
            s_we   = f_we[w_own];
            s_type = f_type[w_own];
            s_addr = f_addr[w_own];
            s_wd   = f_wd[w_own];
            s_pc   = f_pc[w_own];
            s_err  = (s_type == 3'b001) || (s_type == 3'b000 && (s_addr % 4) != 0)
                  || ((s_type == 3'b010 || s_type == 3'b011) && (s_addr % 2) != 0);
            e_last = w_own;
         end
         e_has = w_has;
         e_own = w_own;
         @(negedge clk);
      end
      set_a(0, 0, 0, 0, 0, 0);
      set_b(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      reset     = 1'b1;
      mem_clear = 1'b1;
      set_a(0, 0, 0, 0, 0, 0);
      set_b(0, 0, 0, 0, 0, 0);
      test_reset();
      test_word_write_read();
      test_tie();
      test_errors();
      test_reset_in_access();
      test_passthrough();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
